// File: rtl/fetch_unit_l1.sv
// fetch_unit_l1: instruction fetch stage. Issues pipelined, tagged fetch
// requests, pairs in-order responses with their PCs from a small PC FIFO,
// forwards instruction/PC pairs to decode and drops stale responses after
// a squash redirect.
module fetch_unit_l1 #(
  parameter int          p_opaq_bits     = 8,
  parameter int          p_max_in_flight = 2,
  parameter logic [31:0] p_rst_addr      = 32'h200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [31:0]            mem_req_addr,
  output logic [p_opaq_bits-1:0] mem_req_opaque,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits-1:0] mem_resp_opaque,
  input  logic [31:0]            mem_resp_data,
  output logic                   d_val,
  input  logic                   d_rdy,
  output logic [31:0]            d_inst,
  output logic [31:0]            d_pc,
  input  logic                   squash_val,
  input  logic [31:0]            squash_target
);

  localparam int cnt_w = $clog2(p_max_in_flight + 1);
  // A depth-1 FIFO still needs a one-bit pointer; it wraps explicitly.
  localparam int ptr_w = (p_max_in_flight > 1) ? $clog2(p_max_in_flight) : 1;
  localparam logic [cnt_w-1:0] max_cnt  = cnt_w'(p_max_in_flight);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(p_max_in_flight - 1);

  logic [31:0]            pc;
  logic [p_opaq_bits-1:0] req_opaque;
  logic [p_opaq_bits-1:0] resp_opaque;
  logic [cnt_w-1:0]       in_flight;
  logic [cnt_w-1:0]       drop_cnt;
  logic [31:0]            pc_fifo [p_max_in_flight];
  logic [ptr_w-1:0]       wr_ptr;
  logic [ptr_w-1:0]       rd_ptr;

  logic dropping;
  logic req_fire;
  logic resp_fire;
  logic pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  // Handshake outputs; a squash suppresses issue and forces draining this cycle.
  always_comb begin
    dropping       = (drop_cnt != '0) || squash_val;
    mem_req_val    = rst_n && (in_flight < max_cnt) && !squash_val;
    mem_req_addr   = pc;
    mem_req_opaque = req_opaque;
    mem_resp_rdy   = (rst_n && dropping) ? 1'b1 : d_rdy;
    d_val          = rst_n && !dropping && mem_resp_val;
    d_inst         = mem_resp_data;
    d_pc           = pc_fifo[rd_ptr];
    req_fire       = mem_req_val && mem_req_rdy;
    resp_fire      = mem_resp_val && mem_resp_rdy;
    pop            = resp_fire && !dropping;
  end

  // PC storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_fifo[wr_ptr] <= pc;
    end
  end

  // PC, tag counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= p_rst_addr;
      req_opaque  <= '0;
      resp_opaque <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (resp_fire) begin
        resp_opaque <= resp_opaque + p_opaq_bits'(1);
      end
      if (req_fire) begin
        req_opaque <= req_opaque + p_opaq_bits'(1);
      end
      if (squash_val) begin
        // No push happens in a squash cycle, so aligning pointers empties it.
        pc     <= squash_target;
        rd_ptr <= wr_ptr;
      end else begin
        if (req_fire) begin
          pc     <= pc + 32'd4;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
      end
    end
  end

  // Outstanding-request count and the number of stale responses still to drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   in_flight <= in_flight + cnt_w'(1);
        2'b01:   in_flight <= in_flight - cnt_w'(1);
        default: in_flight <= in_flight;
      endcase
      if (squash_val) begin
        drop_cnt <= in_flight - cnt_w'(resp_fire);
      end else if (resp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - cnt_w'(1);
      end
    end
  end

  // Simulation-only check that responses come back in issue order.
  always_ff @(posedge clk) begin
    if (rst_n && resp_fire) begin
      assert (mem_resp_opaque == resp_opaque);
    end
  end

endmodule

// File: tb/tb_fetch_unit_l1.sv
// Directed bench for fetch_unit_l1 with a 1-cycle pipelined memory model.
module tb_fetch_unit_l1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req_val;
  logic        mem_req_rdy = 1'b1;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_opaque;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [1:0]  mem_resp_opaque;
  logic [31:0] mem_resp_data;
  logic        d_val;
  logic        d_rdy = 1'b1;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic        squash_val = 1'b0;
  logic [31:0] squash_target = 32'h0;

  int compared = 0;
  int mismatched = 0;
  int req_count = 0;

  // Memory model state
  logic [31:0] q_addr [$];
  logic [1:0]  q_op [$];
  int          q_cnt = 0;
  logic [31:0] head_addr = 32'h0;
  logic [1:0]  head_op = 2'd0;
  logic        mem_stall = 1'b0;

  assign mem_resp_val    = (q_cnt != 0) && !mem_stall;
  assign mem_resp_data   = ~head_addr;
  assign mem_resp_opaque = head_op;

  fetch_unit_l1 #(
    .p_opaq_bits(2),
    .p_max_in_flight(2),
    .p_rst_addr(32'h200)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req_val(mem_req_val),
    .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr),
    .mem_req_opaque(mem_req_opaque),
    .mem_resp_val(mem_resp_val),
    .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_opaque(mem_resp_opaque),
    .mem_resp_data(mem_resp_data),
    .d_val(d_val),
    .d_rdy(d_rdy),
    .d_inst(d_inst),
    .d_pc(d_pc),
    .squash_val(squash_val),
    .squash_target(squash_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the memory after it.
  task automatic tick();
    bit          rf;
    bit          pf;
    logic [31:0] cap_addr;
    logic [1:0]  cap_op;
    #1;
    rf = rst_n && mem_req_val && mem_req_rdy;
    pf = rst_n && mem_resp_val && mem_resp_rdy;
    cap_addr = mem_req_addr;
    cap_op   = mem_req_opaque;
    if (rf) begin
      req_count++;
      $display("req  addr=%h tag=%0d", cap_addr, cap_op);
    end
    if (pf) $display("resp addr=%h tag=%0d d_val=%0b", head_addr, head_op, d_val);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q_addr.delete();
      q_op.delete();
    end else begin
      if (pf) begin
        void'(q_addr.pop_front());
        void'(q_op.pop_front());
      end
      if (rf) begin
        q_addr.push_back(cap_addr);
        q_op.push_back(cap_op);
      end
    end
    q_cnt = q_addr.size();
    head_addr = (q_cnt != 0) ? q_addr[0] : 32'h0;
    head_op   = (q_cnt != 0) ? q_op[0] : 2'd0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    squash_val = 1'b0;
    mem_stall = 1'b0;
    d_rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    req_count = 0;
  endtask

  logic [31:0] exp_addr [5] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};
  logic [31:0] exp_op   [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    @(negedge clk);

    // Streaming fetch, tag wrap with 2-bit opaque
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stream_req_val", 32'(mem_req_val), 32'd1);
      chk("stream_req_addr", mem_req_addr, exp_addr[i]);
      chk("stream_req_tag", 32'(mem_req_opaque), exp_op[i]);
      if (i == 0) begin
        chk("stream_first_dval", 32'(d_val), 32'd0);
      end else begin
        chk("stream_dval", 32'(d_val), 32'd1);
        chk("stream_dpc", d_pc, exp_addr[i-1]);
        chk("stream_dinst", d_inst, ~exp_addr[i-1]);
      end
      tick();
    end

    // Decode stall: at most two requests outstanding
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d_rdy = 1'b0;
      #1;
      if (i == 0) chk("stall_addr0", mem_req_addr, 32'h200);
      if (i == 1) chk("stall_addr1", mem_req_addr, 32'h204);
      if (i >= 2) begin
        chk("stall_req_val", 32'(mem_req_val), 32'd0);
        chk("stall_resp_rdy", 32'(mem_resp_rdy), 32'd0);
      end
      tick();
    end
    chk("stall_req_count", 32'(req_count), 32'd2);
    d_rdy = 1'b1;
    #1;
    chk("release_dval0", 32'(d_val), 32'd1);
    chk("release_dpc0", d_pc, 32'h200);
    chk("release_req_val0", 32'(mem_req_val), 32'd0);
    tick();
    #1;
    chk("release_dpc1", d_pc, 32'h204);
    chk("release_req_val1", 32'(mem_req_val), 32'd1);
    chk("release_req_addr1", mem_req_addr, 32'h208);
    tick();

    // Squash with two outstanding, no response in the squash cycle
    do_reset();
    mem_stall = 1'b1;
    d_rdy = 1'b0;
    tick();
    tick();
    squash_val = 1'b1;
    squash_target = 32'h300;
    #1;
    chk("sq_req_val", 32'(mem_req_val), 32'd0);
    chk("sq_dval", 32'(d_val), 32'd0);
    chk("sq_resp_rdy", 32'(mem_resp_rdy), 32'd1);
    tick();
    squash_val = 1'b0;
    mem_stall = 1'b0;
    #1;
    chk("sq_drop1_dval", 32'(d_val), 32'd0);
    chk("sq_drop1_rdy", 32'(mem_resp_rdy), 32'd1);
    chk("sq_drop1_req_val", 32'(mem_req_val), 32'd0);
    tick();
    #1;
    chk("sq_drop2_dval", 32'(d_val), 32'd0);
    chk("sq_redirect_val", 32'(mem_req_val), 32'd1);
    chk("sq_redirect_addr", mem_req_addr, 32'h300);
    chk("sq_redirect_tag", 32'(mem_req_opaque), 32'd2);
    tick();
    d_rdy = 1'b1;
    #1;
    chk("sq_deliver_dval", 32'(d_val), 32'd1);
    chk("sq_deliver_dpc", d_pc, 32'h300);
    chk("sq_deliver_dinst", d_inst, ~32'h300);
    tick();

    // Squash in the same cycle a response arrives
    do_reset();
    mem_stall = 1'b1;
    d_rdy = 1'b0;
    tick();
    tick();
    mem_stall = 1'b0;
    squash_val = 1'b1;
    squash_target = 32'h400;
    #1;
    chk("sqr_dval", 32'(d_val), 32'd0);
    chk("sqr_resp_rdy", 32'(mem_resp_rdy), 32'd1);
    chk("sqr_req_val", 32'(mem_req_val), 32'd0);
    tick();
    squash_val = 1'b0;
    #1;
    chk("sqr_drop_dval", 32'(d_val), 32'd0);
    chk("sqr_drop_rdy", 32'(mem_resp_rdy), 32'd1);
    chk("sqr_redirect_val", 32'(mem_req_val), 32'd1);
    chk("sqr_redirect_addr", mem_req_addr, 32'h400);
    chk("sqr_redirect_tag", 32'(mem_req_opaque), 32'd2);
    tick();
    d_rdy = 1'b1;
    #1;
    chk("sqr_deliver_dval", 32'(d_val), 32'd1);
    chk("sqr_deliver_dpc", d_pc, 32'h400);
    tick();

    // Reset mid-stream with two outstanding
    do_reset();
    mem_stall = 1'b1;
    tick();
    tick();
    mem_stall = 1'b0;
    d_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_val", 32'(mem_resp_val), 32'd1);
    chk("mid_rst_dval", 32'(d_val), 32'd0);
    chk("mid_rst_resp_rdy", 32'(mem_resp_rdy), 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_val", 32'(mem_req_val), 32'd1);
    chk("post_rst_req_addr", mem_req_addr, 32'h200);
    chk("post_rst_req_tag", 32'(mem_req_opaque), 32'd0);
    tick();
    #1;
    chk("post_rst_dval", 32'(d_val), 32'd1);
    chk("post_rst_dpc", d_pc, 32'h200);
    chk("post_rst_req_val2", 32'(mem_req_val), 32'd1);
    chk("post_rst_req_addr2", mem_req_addr, 32'h204);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
